seven_segment_scan: RTL and testbench

Parametrised multiplexed seven-segment display controller: generalises the fixed 4-digit `seven_segment`/`enable` drive of the `Control` top level to N digits. It adds a tear-free shadow-load handshake, leading-zero blanking, per-digit decimal points, and anti-ghosting dead time. It sits between the datapath (which supplies a packed hex value) and the board display pins.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_hex_decode.sv | 19 +
 rtl/seven_segment_scan.sv | 154 +++++++++++++++
 tb/tb_seven_segment_scan.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: glyph table,
// decode helper and counter-width helper.
package seg_pkg;

    // Active-high glyphs, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-segment decoder with blanking and output polarity.
module seg_hex_decode
    import seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] hex,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_high;

    always_comb begin
        seg_high = blank ? 7'h00 : seg_decode(hex);
        seg      = ACTIVE_LOW ? ~seg_high : seg_high;
    end

endmodule

// File: rtl/seven_segment_scan.sv
// N-digit multiplexed seven-segment controller with tear-free shadow load,
// leading-zero blanking, per-digit decimal points and anti-ghosting dead time.
module seven_segment_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned DEAD           = 2,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          ACTIVE_LOW_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_btn,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic                  load_ack,
    output logic [6:0]            seven_segment,
    output logic                  dot,
    output logic [DIGITS-1:0]     enable,
    output logic                  frame_tick
);

    localparam int unsigned       PRE_W    = cnt_width(REFRESH_DIV);
    localparam int unsigned       IDX_W    = cnt_width(DIGITS);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic              DOT_OFF  = ACTIVE_LOW_SEG;
    localparam logic [DIGITS-1:0] EN_OFF   = ACTIVE_LOW_EN ? '1 : '0;

    logic [PRE_W-1:0]    pre_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                pending_reg;
    logic [4*DIGITS-1:0] shadow_value_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic                shadow_blz_reg;
    logic [4*DIGITS-1:0] disp_value_reg;
    logic [DIGITS-1:0]   disp_dp_reg;
    logic                disp_blz_reg;
    logic [6:0]          seg_reg;
    logic                dot_reg;
    logic [DIGITS-1:0]   en_reg;
    logic                ack_reg;
    logic                tick_reg;

    logic                slot_end;
    logic                frame_end;
    logic                in_dead;
    logic [DIGITS-1:0]   lz_blank;
    logic [3:0]          cur_hex;
    logic                cur_blank;
    logic [6:0]          seg_next;
    logic                dot_next;
    logic [DIGITS-1:0]   en_act;
    logic [DIGITS-1:0]   en_next;

    assign slot_end  = (pre_reg == PRE_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);
    assign in_dead   = (32'(pre_reg) < DEAD);

    // A digit blanks only when it and everything to its left are zero; the
    // rightmost digit always shows, so a zero value still reads "0".
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = disp_blz_reg &&
                                      (disp_value_reg[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    assign cur_hex   = disp_value_reg[{idx_reg, 2'b00} +: 4];
    assign cur_blank = in_dead || lz_blank[idx_reg];

    seg_hex_decode #(
        .ACTIVE_LOW (ACTIVE_LOW_SEG)
    ) u_decode (
        .hex   (cur_hex),
        .blank (cur_blank),
        .seg   (seg_next)
    );

    always_comb begin
        en_act = '0;
        if (!in_dead) begin
            en_act[idx_reg] = 1'b1;
        end
        en_next  = ACTIVE_LOW_EN ? ~en_act : en_act;
        dot_next = in_dead ? DOT_OFF : (disp_dp_reg[idx_reg] ^ ACTIVE_LOW_SEG);
    end

    always_ff @(posedge clk or negedge reset_btn) begin
        if (!reset_btn) begin
            pre_reg          <= '0;
            idx_reg          <= '0;
            pending_reg      <= 1'b0;
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            shadow_blz_reg   <= 1'b0;
            disp_value_reg   <= '0;
            disp_dp_reg      <= '0;
            disp_blz_reg     <= 1'b0;
            seg_reg          <= SEG_OFF;
            dot_reg          <= DOT_OFF;
            en_reg           <= EN_OFF;
            ack_reg          <= 1'b0;
            tick_reg         <= 1'b0;
        end else begin
            pre_reg <= slot_end ? '0 : pre_reg + 1'b1;
            if (slot_end) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end

            // The display registers only change on a frame boundary, so a
            // frame is never drawn from two different values.
            ack_reg <= 1'b0;
            if (frame_end && load) begin
                disp_value_reg <= value;
                disp_dp_reg    <= dp;
                disp_blz_reg   <= blank_lz;
                pending_reg    <= 1'b0;
                ack_reg        <= 1'b1;
            end else if (frame_end && pending_reg) begin
                disp_value_reg <= shadow_value_reg;
                disp_dp_reg    <= shadow_dp_reg;
                disp_blz_reg   <= shadow_blz_reg;
                pending_reg    <= 1'b0;
                ack_reg        <= 1'b1;
            end else if (load) begin
                shadow_value_reg <= value;
                shadow_dp_reg    <= dp;
                shadow_blz_reg   <= blank_lz;
                pending_reg      <= 1'b1;
            end

            tick_reg <= frame_end;
            seg_reg  <= seg_next;
            dot_reg  <= dot_next;
            en_reg   <= en_next;
        end
    end

    assign seven_segment = seg_reg;
    assign dot           = dot_reg;
    assign enable        = en_reg;
    assign load_ack      = ack_reg;
    assign frame_tick    = tick_reg;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan (4 digits, 8-cycle slots, dead time 2, active-low).
module tb_seven_segment_scan;

    localparam int DIGITS = 4;
    localparam int RD     = 8;
    localparam int DEAD   = 2;
    localparam int FRAME  = DIGITS * RD;

    logic        clk = 1'b0;
    logic        reset_btn = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic        load = 1'b0;
    logic        load_ack;
    logic [6:0]  seven_segment;
    logic        dot;
    logic [3:0]  enable;
    logic        frame_tick;

    seven_segment_scan #(
        .DIGITS         (DIGITS),
        .REFRESH_DIV    (RD),
        .DEAD           (DEAD),
        .ACTIVE_LOW_SEG (1'b1),
        .ACTIVE_LOW_EN  (1'b1)
    ) dut (
        .clk           (clk),
        .reset_btn     (reset_btn),
        .value         (value),
        .dp            (dp),
        .blank_lz      (blank_lz),
        .load          (load),
        .load_ack      (load_ack),
        .seven_segment (seven_segment),
        .dot           (dot),
        .enable        (enable),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int ack_seen = 0;

    // Reference model: cycle count since reset plus what is on display / waiting.
    int          t;
    logic [15:0] m_val, m_sval;
    logic [3:0]  m_dp, m_sdp;
    logic        m_blz, m_sblz, m_pend;

    logic [6:0] hex_font [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // What each digit showed during its most recent active slot.
    logic [6:0] cap_seg [4];
    logic       cap_dot [4];

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        blz;
        logic [27:0] seg;    // digit3..digit0, 7 bits each, pin level
        logic [3:0]  dot_n;  // pin level per digit
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // One clock: predict outputs from the model, advance, compare, update model.
    task automatic step();
        int          pre, idx;
        bit          fb;
        logic [15:0] upper;
        logic [3:0]  e_en;
        logic [6:0]  e_seg;
        logic        e_dot, e_ack, e_tick;
        pre   = t % RD;
        idx   = (t / RD) % DIGITS;
        fb    = (pre == RD - 1) && (idx == DIGITS - 1);
        upper = m_val >> (4 * idx);
        if (pre < DEAD) begin
            e_en  = 4'hF;
            e_seg = 7'h7F;
            e_dot = 1'b1;
        end else begin
            e_en  = ~(4'b0001 << idx);
            e_dot = ~m_dp[idx];
            if (m_blz && idx != 0 && upper == 16'h0) e_seg = 7'h7F;
            else                                      e_seg = ~hex_font[upper[3:0]];
        end
        e_ack  = fb && (load || m_pend);
        e_tick = fb;

        @(posedge clk);
        #1;
        n_vec++;
        if ({enable, seven_segment, dot, load_ack, frame_tick} !== {e_en, e_seg, e_dot, e_ack, e_tick}
            || $countones(~enable) > 1) begin
            n_bad++;
            $display("FAIL cycle t=%0d: got en=%h seg=%h dot=%b ack=%b tick=%b, want en=%h seg=%h dot=%b ack=%b tick=%b",
                     t, enable, seven_segment, dot, load_ack, frame_tick, e_en, e_seg, e_dot, e_ack, e_tick);
        end
        if (load_ack === 1'b1) ack_seen++;
        for (int k = 0; k < DIGITS; k++) begin
            if (enable == ~(4'b0001 << k)) begin
                cap_seg[k] = seven_segment;
                cap_dot[k] = dot;
            end
        end

        if (fb && load) begin
            m_val = value; m_dp = dp; m_blz = blank_lz; m_pend = 1'b0;
        end else if (fb && m_pend) begin
            m_val = m_sval; m_dp = m_sdp; m_blz = m_sblz; m_pend = 1'b0;
        end else if (load) begin
            m_sval = value; m_sdp = dp; m_sblz = blank_lz; m_pend = 1'b1;
        end
        t++;
    endtask

    task automatic apply_reset(input int hold);
        reset_btn = 1'b0;
        load      = 1'b0;
        #2;
        check("reset_outputs", {20'h0, enable, seven_segment, dot},
              {20'h0, 4'hF, 7'h7F, 1'b1});
        check("reset_strobes", {30'h0, load_ack, frame_tick}, 32'h0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset_btn = 1'b1;
        t = 0;
        m_val = '0; m_sval = '0; m_dp = '0; m_sdp = '0;
        m_blz = 1'b0; m_sblz = 1'b0; m_pend = 1'b0;
    endtask

    task automatic to_fb();
        while ((t % FRAME) != FRAME - 1) step();
    endtask

    task automatic clear_caps();
        for (int k = 0; k < DIGITS; k++) begin
            cap_seg[k] = 7'h55;
            cap_dot[k] = 1'bx;
        end
    endtask

    initial begin
        tbl[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
        tbl[1] = '{16'h0030, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b0111};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        tbl[3] = '{16'h8000, 4'b0101, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}, 4'b1010};
        tbl[4] = '{16'h0E0D, 4'b0000, 1'b1, {7'h7F, 7'h06, 7'h40, 7'h21}, 4'b1111};
        tbl[5] = '{16'h0E0D, 4'b0000, 1'b0, {7'h40, 7'h06, 7'h40, 7'h21}, 4'b1111};

        #3;
        apply_reset(3);

        // First enable is digit 0, three cycles after release.
        step(); step();
        check("pre_dead_enable", {28'h0, enable}, {28'h0, 4'hF});
        step();
        check("first_enable", {28'h0, enable}, {28'h0, 4'hE});

        // Table-driven frame contents, each loaded on the frame boundary.
        for (int v = 0; v < 6; v++) begin
            to_fb();
            value = tbl[v].val; dp = tbl[v].dp; blank_lz = tbl[v].blz; load = 1'b1;
            step();
            check("bypass_ack", {31'h0, load_ack}, 32'h1);
            load = 1'b0; value = 16'($urandom); dp = 4'($urandom); blank_lz = 1'($urandom);
            clear_caps();
            repeat (FRAME) step();
            check("frame_segs", {4'h0, cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]},
                  {4'h0, tbl[v].seg});
            check("frame_dots", {28'h0, cap_dot[3], cap_dot[2], cap_dot[1], cap_dot[0]},
                  {28'h0, tbl[v].dot_n});
            $display("vector %0d: value=%h dp=%b blz=%b segs=%h %h %h %h", v, tbl[v].val, tbl[v].dp,
                     tbl[v].blz, cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]);
        end

        // Shadow: two mid-frame loads, last one wins, single ack at FB+1.
        to_fb();
        step();
        repeat (5) step();
        value = 16'h0001; dp = 4'b0000; blank_lz = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        repeat (6) step();
        value = 16'h0002; load = 1'b1;
        step();
        load = 1'b0; value = 16'h0007;
        ack_seen = 0;
        to_fb();
        check("no_early_ack", ack_seen, 0);
        step();
        check("shadow_ack_at_fb", {31'h0, load_ack}, 32'h1);
        clear_caps();
        repeat (FRAME) step();
        check("shadow_ack_count", ack_seen, 1);
        check("shadow_digit0", {25'h0, cap_seg[0]}, {25'h0, 7'h24});
        $display("shadow: loads 0001 then 0002, acks=%0d digit0=%h", ack_seen, cap_seg[0]);

        // Reset in the middle of a pending load discards it.
        to_fb();
        step();
        repeat (4) step();
        value = 16'h0055; dp = 4'b1111; blank_lz = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        repeat (3) step();
        apply_reset(1);
        ack_seen = 0;
        clear_caps();
        repeat (2 * FRAME) step();
        check("reset_midload_ack", ack_seen, 0);
        check("reset_midload_digit3", {25'h0, cap_seg[3]}, {25'h0, 7'h40});
        check("reset_midload_dot0", {31'h0, cap_dot[0]}, 32'h1);
        $display("reset mid-load: acks=%0d digit3=%h", ack_seen, cap_seg[3]);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            load     = ($urandom_range(0, 9) == 0);
            value    = 16'($urandom);
            dp       = 4'($urandom);
            blank_lz = 1'($urandom);
            if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            if (load) $display("random load t=%0d: value=%h dp=%b blz=%b", t, value, dp, blank_lz);
            step();
        end
        load = 1'b0;
        repeat (FRAME) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
